// File: rtl/bs_pkg.sv
// -----------------------------------------------------------------------------
// bs_pkg
// Shared types and constants for the Black-Scholes result framer.
//   FRAME_BYTES    : bytes per serialized result frame (hdr, index, 4 result)
//   FRAME_HDR_DEF  : default first byte of every frame
//   framer_state_t : framer FSM state encoding
//   bs_word_t      : one 32-bit pricing result
//   idx_width()    : width of a core index for n cores (at least 1 bit)
// -----------------------------------------------------------------------------
package bs_pkg;

  localparam int         FRAME_BYTES   = 6;
  localparam logic [7:0] FRAME_HDR_DEF = 8'hA5;

  typedef enum logic {IDLE, SEND} framer_state_t;

  typedef logic [31:0] bs_word_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bs_result_framer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans req starting at ptr and
// wrapping modulo N; the first set bit wins. The caller owns ptr and advances
// it after each grant.
// Ports:
//   req       : N-bit request vector
//   ptr       : index where the scan starts (must be < N)
//   grant_idx : index of the winning request (0 when none)
//   grant_any : at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import bs_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Walk the offsets from farthest to nearest so the closest request to ptr
  // is the last assignment and therefore the winner.
  always_comb begin : scan
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) begin
        grant_idx = IW'(idx);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bs_result_framer.sv
// -----------------------------------------------------------------------------
// bs_result_framer
// Captures 32-bit results from BSMODS Black-Scholes cores on their ap_done
// pulses, grants pending results round-robin and serializes each one as a
// 6-byte frame onto a UART TX byte stream:
//   FRAME_HDR, core index, result[31:24], [23:16], [15:8], [7:0]
// Ports:
//   clock      : sole clock, rising edge
//   reset      : asynchronous, active-low
//   BS_DONE    : per-core ap_done pulse
//   ap_return  : per-core result, core i at [32*i +: 32], valid with BS_DONE[i]
//   tx_data    : byte to the UART TX FIFO
//   tx_valid   : tx_data is valid
//   tx_ready   : UART accepts the byte on tx_valid && tx_ready
//   result_ack : one-cycle pulse when core i's result enters the serializer
//   overrun    : sticky, core i finished while its previous result was pending
//   dbg_state  : current framer FSM state
//
// Handshake: a byte moves on a rising edge where tx_valid && tx_ready. Once
// tx_valid is raised it stays high until the last byte of the frame has been
// accepted, and tx_data holds its value on every edge without a handshake.
// All outputs are registered; tx_ready only steers next-state logic.
// -----------------------------------------------------------------------------
module bs_result_framer
  import bs_pkg::*;
#(
  parameter int         BSMODS    = 2,
  parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BSMODS-1:0]     BS_DONE,
  input  logic [BSMODS*32-1:0]  ap_return,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [BSMODS-1:0]     result_ack,
  output logic [BSMODS-1:0]     overrun,
  output framer_state_t         dbg_state
);

  localparam int         IW        = idx_width(BSMODS);
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  // Per-core capture state
  bs_word_t            cap_q [BSMODS];
  logic [BSMODS-1:0]   pend_q;
  logic [BSMODS-1:0]   overrun_q;

  // Serializer state
  framer_state_t       state_q;
  logic [2:0]          byte_cnt_q;
  logic [39:0]         frame_q;      // bytes 1..5 still to be presented
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic [BSMODS-1:0]   ack_q;
  logic [IW-1:0]       ptr_q;

  // Arbitration and next-state helpers
  logic [IW-1:0]       grant_idx;
  logic                grant_any;
  logic                load;
  logic [BSMODS-1:0]   load_vec;
  logic [7:0]          grant_byte;
  bs_word_t            grant_word;
  logic [IW-1:0]       ptr_d;
  logic                hs;

  rr_arbiter #(.N(BSMODS)) u_arb (
    .req       (pend_q),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    load       = (state_q == IDLE) && grant_any;
    load_vec   = '0;
    if (load) load_vec[grant_idx] = 1'b1;
    grant_byte = '0;
    grant_byte[IW-1:0] = grant_idx;
    grant_word = cap_q[grant_idx];
    ptr_d      = (grant_idx == IW'(BSMODS - 1)) ? '0 : grant_idx + IW'(1);
    hs         = tx_valid_q && tx_ready;
  end

  // Capture: a core may deliver a new result on the very edge its old one is
  // loaded into the serializer. The load reads the old cap value this edge,
  // so the new one is accepted and the core stays pending without overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q    <= '0;
      overrun_q <= '0;
      for (int i = 0; i < BSMODS; i++) cap_q[i] <= '0;
    end else begin
      for (int i = 0; i < BSMODS; i++) begin
        if (BS_DONE[i] && (!pend_q[i] || load_vec[i])) begin
          cap_q[i]  <= ap_return[i*32 +: 32];
          pend_q[i] <= 1'b1;
        end else if (load_vec[i]) begin
          pend_q[i] <= 1'b0;
        end
        if (BS_DONE[i] && pend_q[i] && !load_vec[i]) overrun_q[i] <= 1'b1;
      end
    end
  end

  // Framer FSM with registered outputs. The header byte is presented directly
  // on load; the remaining five bytes shift out of frame_q MSB first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      frame_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ack_q      <= '0;
      ptr_q      <= '0;
    end else begin
      ack_q <= load_vec;
      case (state_q)
        IDLE: begin
          if (load) begin
            frame_q    <= {grant_byte, grant_word};
            tx_data_q  <= FRAME_HDR;
            tx_valid_q <= 1'b1;
            byte_cnt_q <= '0;
            ptr_q      <= ptr_d;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (byte_cnt_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              tx_data_q  <= frame_q[39:32];
              frame_q    <= {frame_q[31:0], 8'h00};
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign result_ack = ack_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bs_result_framer.sv
// -----------------------------------------------------------------------------
// tb_bs_result_framer
// Directed bench for bs_result_framer with two cores. Expected frame bytes are
// queued by the stimulus and popped by a byte monitor on each accepted byte.
// -----------------------------------------------------------------------------
module tb_bs_result_framer;
  import bs_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    bs_done;
  logic [63:0]   ap_return;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [1:0]    result_ack;
  logic [1:0]    overrun;
  framer_state_t dbg_state;

  always #5 clock = ~clock;

  bs_result_framer #(.BSMODS(2), .FRAME_HDR(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .BS_DONE    (bs_done),
    .ap_return  (ap_return),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .result_ack (result_ack),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       stall_hold = 1'b0;
  logic [7:0] held_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1, so at the negedge tx_valid/tx_ready show
  // exactly what the next rising edge will see.
  always @(negedge clock) begin
    if (!reset) begin
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check_val("stall_valid", {31'd0, tx_valid}, 32'd1);
        check_val("stall_data", {24'd0, tx_data}, {24'd0, held_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check_val("byte", {24'd0, tx_data}, {24'd0, e});
        end
      end
      stall_hold = tx_valid && !tx_ready;
      held_data  = tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] idx, input logic [31:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(idx);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Drives BS_DONE for one cycle; ap_return carries garbage otherwise so a
  // capture without BS_DONE would show up in the frames.
  task automatic pulse_done(input logic [1:0] m, input logic [31:0] r0,
                            input logic [31:0] r1);
    bs_done   = m;
    ap_return = {r1, r0};
    step(1);
    bs_done   = 2'b00;
    ap_return = {$urandom, $urandom};
  endtask

  // Runs until all expected bytes are out and the framer is idle. With bp set
  // tx_ready follows the pattern 1,0,0,1 repeating.
  task automatic drain(input bit bp);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_valid) && k < 300) begin
      tx_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      step(1);
      k++;
    end
    tx_ready = 1'b1;
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
    check_val("drain_idle", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seen;
    bs_done   = 2'b00;
    ap_return = '0;
    tx_ready  = 1'b1;

    // Reset values
    #3;
    check_val("rst_valid", {31'd0, tx_valid}, 32'd0);
    check_val("rst_data", {24'd0, tx_data}, 32'd0);
    check_val("rst_ack", {30'd0, result_ack}, 32'd0);
    check_val("rst_overrun", {30'd0, overrun}, 32'd0);
    check_val("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    step(2);
    reset = 1'b1;
    step(1);

    // Single result, including exact latency of ack and header
    push_frame(8'h00, 32'h12345678);
    pulse_done(2'b01, 32'h12345678, 32'hDEAD0000);
    step(1);
    check_val("t1_ack", {30'd0, result_ack}, 32'h1);
    check_val("t1_valid", {31'd0, tx_valid}, 32'd1);
    check_val("t1_hdr", {24'd0, tx_data}, 32'hA5);
    step(1);
    check_val("t1_ack_1cyc", {30'd0, result_ack}, 32'h0);
    check_val("t1_byte1", {24'd0, tx_data}, 32'h00);
    drain(1'b0);
    check_val("t1_overrun", {30'd0, overrun}, 32'h0);

    // Simultaneous done, twice; second frame starts 7 cycles after the first
    do_reset();
    push_frame(8'h00, 32'hAAAA0001);
    push_frame(8'h01, 32'hBBBB0002);
    pulse_done(2'b11, 32'hAAAA0001, 32'hBBBB0002);
    step(1);
    check_val("t2a_ack0", {30'd0, result_ack}, 32'h1);
    step(7);
    check_val("t2a_ack1", {30'd0, result_ack}, 32'h2);
    drain(1'b0);
    push_frame(8'h00, 32'h11112222);
    push_frame(8'h01, 32'h33334444);
    pulse_done(2'b11, 32'h11112222, 32'h33334444);
    step(1);
    check_val("t2b_ack0", {30'd0, result_ack}, 32'h1);
    step(7);
    check_val("t2b_ack1", {30'd0, result_ack}, 32'h2);
    drain(1'b0);

    // Backpressure
    push_frame(8'h00, 32'hCAFEF00D);
    pulse_done(2'b01, 32'hCAFEF00D, 32'h0);
    drain(1'b1);

    // Overrun: core 1 finishes twice while core 0's frame is in flight
    push_frame(8'h00, 32'h55667788);
    push_frame(8'h01, 32'h00000001);
    pulse_done(2'b01, 32'h55667788, 32'hFFFFFFFF);
    step(1);
    pulse_done(2'b10, 32'hFFFFFFFF, 32'h00000001);
    pulse_done(2'b10, 32'hFFFFFFFF, 32'h00000002);
    check_val("t4_overrun", {30'd0, overrun}, 32'h2);
    drain(1'b0);
    check_val("t4_overrun_sticky", {30'd0, overrun}, 32'h2);

    // Same-edge load and capture on core 0
    push_frame(8'h01, 32'h13579BDF);
    push_frame(8'h00, 32'h2468ACE0);
    push_frame(8'h00, 32'hFEEDBEEF);
    pulse_done(2'b10, 32'h0, 32'h13579BDF);
    step(2);
    pulse_done(2'b01, 32'h2468ACE0, 32'h0);
    step(4);
    pulse_done(2'b01, 32'hFEEDBEEF, 32'h0);
    check_val("t5_ack_same_edge", {30'd0, result_ack}, 32'h1);
    check_val("t5_no_overrun", {30'd0, overrun}, 32'h2);
    drain(1'b0);
    check_val("t5_overrun_end", {30'd0, overrun}, 32'h2);

    // Reset during byte 3, with core 1 also pending
    push_frame(8'h00, 32'hDEADBEEF);
    pulse_done(2'b01, 32'hDEADBEEF, 32'h0);
    step(1);
    pulse_done(2'b10, 32'h0, 32'h0BADF00D);
    step(2);
    check_val("t6_byte3", {24'd0, tx_data}, 32'hAD);
    reset = 1'b0;
    #1;
    check_val("t6_rst_valid", {31'd0, tx_valid}, 32'd0);
    check_val("t6_rst_data", {24'd0, tx_data}, 32'd0);
    check_val("t6_rst_overrun", {30'd0, overrun}, 32'd0);
    check_val("t6_rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    check_val("t6_unsent", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    step(2);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      step(1);
      if (tx_valid || (result_ack != 2'b00)) seen++;
    end
    check_val("t6_quiet", 32'(seen), 32'd0);
    push_frame(8'h01, 32'h00C0FFEE);
    pulse_done(2'b10, 32'h0, 32'h00C0FFEE);
    step(1);
    check_val("t6_new_ack", {30'd0, result_ack}, 32'h2);
    drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bs_result_framer.md
# bs_result_framer

Collects 32-bit pricing results from the `BSMODS` Black-Scholes cores in `BSContainer` and serializes them as 6-byte frames onto the UART transmit byte stream in `design_1`. The block sits directly downstream of the cores' `ap_return` and `BS_DONE` outputs. Each core's result is captured on its `ap_done` pulse, so results are never lost while the UART is busy. Pending results are granted round-robin, and the block pulses a per-core acknowledge when it takes ownership of a result.

## Interface
- `BSMODS`, default 2: number of BS cores; 1..255.
- `FRAME_HDR`, default 8'hA5: first byte of every frame.
- `clock`  input  1: sole clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `BS_DONE`  input  BSMODS: per-core `ap_done`; a one-cycle pulse.
- `ap_return`  input  BSMODS×32: per-core result; valid only in the cycle its `BS_DONE` bit is high.
- `tx_data`  output  8: byte to the UART TX FIFO.
- `tx_valid`  output  1: `tx_data` is valid.
- `tx_ready`  input  1: the UART accepts the byte when `tx_valid && tx_ready` at a rising edge.
- `result_ack`  output  BSMODS: one-cycle pulse when core i's result is loaded into the serializer.
- `overrun`  output  BSMODS: sticky flag; core i finished while its previous result was still pending. Cleared only by reset.

## Operation
- **Per-core capture.** On an edge with `BS_DONE[i]=1`, `cap[i] <= ap_return[i]` and `pend[i] <= 1`.
- **Overrun.** If `BS_DONE[i]=1` while `pend[i]=1` and core i is not being loaded on that edge:
  - the new result is dropped;
  - `cap[i]` keeps its old value;
  - `overrun[i] <= 1`.
- **Same-edge load and capture.** If core i is loaded and `BS_DONE[i]=1` on the same edge:
  - the loaded value is the old `cap[i]`;
  - the new value is captured and `pend[i]` stays 1;
  - no overrun is flagged.
- **Arbitration.** A round-robin pointer `ptr` resets to 0.
  - Grant goes to the first i with `pend[i]=1`, scanning `ptr, ptr+1, …` mod BSMODS.
  - After granting core g, `ptr <= (g+1) mod BSMODS`.
- **State machine:**
  - IDLE: if any `pend` bit is set, on the next edge:
    - load the frame shift register with core g's result;
    - clear `pend[g]`;
    - pulse `result_ack[g]` for one cycle;
    - set `byte_cnt <= 0`;
    - go to SEND.
  - SEND: `tx_valid=1` and `tx_data=frame[byte_cnt]`.
    - On handshake with `byte_cnt<5`: `byte_cnt++`.
    - On handshake with `byte_cnt=5`: go to IDLE.
    - Without handshake: `tx_data` and `byte_cnt` hold.
- **Frame byte order.**
  - byte 0: `FRAME_HDR`
  - byte 1: core index g as 8 bits, zero-extended
  - bytes 2..5: the 32-bit result, MSB first (`[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`)
- **Reset (asynchronous).** Asserting `reset` mid-frame aborts the frame immediately; no partial continuation after release. Reset values:
  - `tx_valid=0`, `tx_data=0`
  - `result_ack=0`, `overrun=0`
  - `pend=0`, `cap=0`
  - `ptr=0`, `byte_cnt=0`, state IDLE

## Timing
- `BS_DONE[i]` high in cycle t → `pend[i]=1` in cycle t+1.
- If the block is in IDLE at t+1, then in cycle t+2:
  - `result_ack[i]=1`;
  - `tx_valid=1` with `tx_data=FRAME_HDR`.
- With `tx_ready` held at 1, a frame occupies exactly 6 cycles of `tx_valid`.
- One IDLE cycle separates back-to-back frames, so sustained throughput is 7 cycles per result.
- `tx_data`/`tx_valid` never change while `tx_valid=1 && tx_ready=0`.
- `tx_valid` never falls mid-frame.
- All outputs are registered; there is no combinational path from `tx_ready` to `tx_data` or `tx_valid`.

## Structure
- Package `bs_pkg`:
  - `FRAME_BYTES=6`;
  - `typedef enum logic {IDLE, SEND} framer_state_t`;
  - `typedef logic [31:0] bs_word_t`.
- `FRAME_HDR` keeps its parameter default, equal to `bs_pkg`'s header constant.
- One sub-module, `rr_arbiter`:
  - parameter N;
  - inputs `req[N]`, `ptr`;
  - outputs `grant_idx`, `grant_any`;
  - purely combinational;
  - `ptr` update lives in the framer.

## Test plan
- Single result: `BS_DONE=2'b01` with `ap_return[0]=32'h12345678`, `tx_ready=1` → bytes A5,00,12,34,56,78; `result_ack=2'b01` for one cycle at t+2.
- Simultaneous done: `BS_DONE=2'b11` with results 32'hAAAA0001 and 32'hBBBB0002 → core-0 frame first, then core-1 frame; a second simultaneous pair is served core 0 then core 1 again (ptr wrapped to 0).
- Backpressure: `tx_ready` toggled 1,0,0,1,… → every byte is held stable while stalled; the frame content is unchanged and no bytes are duplicated or skipped.
- Overrun: core 1 finishes with 32'h1 while the core-0 frame is being sent, then finishes again with 32'h2 before being granted → frame carries 32'h1; `overrun=2'b10` stays set.
- Same-edge load and capture: core 0's `BS_DONE` coincides with its load edge → the old value is sent; the new value is sent in the next frame; `overrun` stays 0.
- Reset mid-frame: `reset` is pulled low during byte 3 → `tx_valid=0` and `pend=0` immediately; after release, no output until a new `BS_DONE`.
